// File: rtl/seq_ax_mlp_classifier.sv
// Time-multiplexed two-layer MLP classifier built around one shared MAC.
// Weights and biases stream from a combinational ROM; the result is an argmax class.
module seq_ax_mlp_classifier #(
    parameter int NI       = 11,
    parameter int IW       = 4,
    parameter int NH       = 4,
    parameter int NO       = 7,
    parameter int WW       = 8,
    parameter int AW       = 16,
    parameter int HW       = 8,
    parameter int AX_TRUNC = 0,
    parameter int ADW      = 7,
    parameter int CW       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NI*IW-1:0]   inp,
    output logic [ADW-1:0]     w_addr,
    input  logic [WW-1:0]      w_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      out_class,
    output logic [AW-2:0]      out_score,
    output logic               busy
);

    localparam int XW      = (IW > HW) ? IW : HW;
    localparam int PW      = WW - 1 + XW;
    localparam int KW      = $clog2(((NI > NH) ? NI : NH) + 2);
    localparam int NW      = $clog2(((NH > NO) ? NH : NO) + 1);
    localparam int L1_BASE = NH * (NI + 1);
    localparam logic [PW-1:0] TMASK = {PW{1'b1}} << AX_TRUNC;

    typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     idx_q, idx_d;
    logic [KW-1:0]     k_q, k_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [NI*IW-1:0]  x_q, x_d;
    logic [HW-1:0]     hid_q [NH];
    logic [HW-1:0]     hid_d [NH];
    logic [CW-1:0]     cls_q, cls_d;
    logic [AW-2:0]     score_q, score_d;

    logic [KW-1:0]     kk;
    logic [XW-1:0]     xop;
    logic [WW-2:0]     mag;
    logic [PW-1:0]     prod;
    logic [AW-1:0]     pext;
    logic [AW-1:0]     bias;
    logic [HW-1:0]     hsat;
    logic [AW-2:0]     s;
    logic              wb;
    int                j;

    // Shared datapath: operand select, magnitude product, truncation, address.
    always_comb begin
        kk  = k_q - 1'b1;
        xop = '0;
        for (int i = 0; i < NI; i++)
            if (state_q == L0 && kk == KW'(i)) xop = XW'(x_q[i*IW +: IW]);
        for (int i = 0; i < NH; i++)
            if (state_q == L1 && kk == KW'(i)) xop = XW'(hid_q[i]);

        mag  = w_data[WW-1] ? (~w_data[WW-2:0] + 1'b1) : w_data[WW-2:0];
        prod = (PW'(mag) * PW'(xop)) & TMASK;
        pext = AW'(prod);
        bias = {{(AW-WW){w_data[WW-1]}}, w_data};

        hsat = acc_q[AW-1] ? '0 :
               (|acc_q[AW-2:HW]) ? '1 : acc_q[HW-1:0];
        s    = acc_q[AW-1] ? '0 : acc_q[AW-2:0];

        wb = (state_q == L0 && k_q == KW'(NI + 1)) ||
             (state_q == L1 && k_q == KW'(NH + 1));

        j = (k_q == '0) ? NI : int'(kk);
        if (state_q == L1 && k_q == '0) j = NH;

        case (state_q)
            L0:      w_addr = ADW'(int'(idx_q) * (NI + 1) + j);
            L1:      w_addr = ADW'(L1_BASE + int'(idx_q) * (NH + 1) + j);
            default: w_addr = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        acc_d   = acc_q;
        x_d     = x_q;
        hid_d   = hid_q;
        cls_d   = cls_q;
        score_d = score_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = inp;
                    idx_d   = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = L0;
                end
            end
            L0, L1: begin
                if (k_q == '0)
                    acc_d = bias;
                else if (!wb)
                    acc_d = w_data[WW-1] ? acc_q - pext : acc_q + pext;

                if (!wb) begin
                    k_d = k_q + 1'b1;
                end else begin
                    k_d = '0;
                    if (state_q == L0) begin
                        for (int i = 0; i < NH; i++)
                            if (idx_q == NW'(i)) hid_d[i] = hsat;
                        if (idx_q == NW'(NH - 1)) begin
                            idx_d   = '0;
                            state_d = L1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        // Strict compare: ties keep the lower class index.
                        if (idx_q == '0 || s > score_q) begin
                            score_d = s;
                            cls_d   = CW'(idx_q);
                        end
                        if (idx_q == NW'(NO - 1)) begin
                            idx_d   = '0;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            cls_q   <= '0;
            score_q <= '0;
            for (int i = 0; i < NH; i++) hid_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            cls_q   <= cls_d;
            score_q <= score_d;
            hid_q   <= hid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == L0) || (state_q == L1);
    assign out_class = cls_q;
    assign out_score = score_q;

endmodule

// File: tb/tb_seq_ax_mlp_classifier.sv
// Directed bench for seq_ax_mlp_classifier: default, truncating (AX_TRUNC=2)
// and narrow-hidden (HW=7) builds run in lockstep from one shared ROM image.
module tb_seq_ax_mlp_classifier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [43:0] inp;

    logic        in_ready,  in_ready_t,  in_ready_s;
    logic [6:0]  w_addr,    w_addr_t,    w_addr_s;
    logic [7:0]  w_data,    w_data_t,    w_data_s;
    logic        out_valid, out_valid_t, out_valid_s;
    logic [2:0]  out_class, out_class_t, out_class_s;
    logic [14:0] out_score, out_score_t, out_score_s;
    logic        busy,      busy_t,      busy_s;

    logic [7:0]  rom [128];

    assign w_data   = rom[w_addr];
    assign w_data_t = rom[w_addr_t];
    assign w_data_s = rom[w_addr_s];

    seq_ax_mlp_classifier dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inp(inp), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_class(out_class), .out_score(out_score),
        .busy(busy)
    );

    seq_ax_mlp_classifier #(.AX_TRUNC(2)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .inp(inp), .w_addr(w_addr_t), .w_data(w_data_t),
        .out_valid(out_valid_t), .out_ready(out_ready),
        .out_class(out_class_t), .out_score(out_score_t), .busy(busy_t)
    );

    seq_ax_mlp_classifier #(.HW(7)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .inp(inp), .w_addr(w_addr_s), .w_data(w_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_class(out_class_s), .out_score(out_score_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_rom();
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    endtask

    task automatic set_l0(input int h, input int jj, input int v);
        rom[h*12 + jj] = 8'(v);
    endtask

    task automatic set_l1(input int o, input int jj, input int v);
        rom[48 + o*5 + jj] = 8'(v);
    endtask

    task automatic load_bias_only();
        int b [7];
        b = '{3, 21, 31, 29, 18, 14, -24};
        clr_rom();
        for (int o = 0; o < 7; o++) set_l1(o, 4, b[o]);
    endtask

    task automatic run(input logic [43:0] v, input string tag);
        int n;
        check({tag, "_rdy"}, in_ready, 1);
        inp      = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        inp      = ~v;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_addr"}, w_addr, 11);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, 94);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, in_ready, 1);
        check({tag, "_ov0"}, out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [43:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inp       = '0;
        clr_rom();
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_class", out_class, 0);
        check("rst_out_score", out_score, 0);
        check("rst_busy", busy, 0);
        check("rst_w_addr", w_addr, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Bias-only: winner is class 2 with 31; negative bias clamps to 0.
        load_bias_only();
        run(44'h123_4567_89AB, "bias");
        check("bias_class", out_class, 2);
        check("bias_score", out_score, 31);

        // Backpressure: DONE holds, new vector is ignored.
        inp      = 44'hFFF_FFFF_FFFF;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_class", out_class, 2);
            check("bp_score", out_score, 31);
            check("bp_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        release_out("bp");

        // Tie-break keeps the lower index.
        clr_rom();
        set_l1(0, 4, 5);
        set_l1(1, 4, 9);
        set_l1(2, 4, 9);
        run(44'h0, "tie");
        check("tie_class", out_class, 1);
        check("tie_score", out_score, 9);
        release_out("tie");

        // Signed weights: hid0 = 10 - 3*2 + 2*5 = 14; class5 = 2*14-1 = 27.
        clr_rom();
        set_l0(0, 11, 10);
        set_l0(0, 2, -3);
        set_l0(0, 3, 2);
        set_l1(5, 0, 2);
        set_l1(5, 4, -1);
        set_l1(6, 0, -1);
        set_l1(6, 4, 20);
        v = '0;
        v[8 +: 4]  = 4'd2;
        v[12 +: 4] = 4'd5;
        v[0 +: 4]  = 4'd9;
        v[40 +: 4] = 4'd15;
        run(v, "mix");
        check("mix_class", out_class, 5);
        check("mix_score", out_score, 27);
        check("mix_class_t", out_class_t, 5);
        check("mix_score_t", out_score_t, 27);
        release_out("mix");

        // Truncation: 1*7 becomes 4 when two product LSBs are dropped.
        clr_rom();
        set_l0(0, 0, 1);
        set_l1(3, 0, 1);
        v = '0;
        v[0 +: 4] = 4'd7;
        run(v, "trunc");
        check("trunc_class", out_class, 3);
        check("trunc_score", out_score, 7);
        check("trunc_valid_t", out_valid_t, 1);
        check("trunc_class_t", out_class_t, 3);
        check("trunc_score_t", out_score_t, 4);
        release_out("trunc");

        // Saturation: 100 + 4*15 = 160 clamps to 127 with 7-bit hidden.
        clr_rom();
        set_l0(0, 11, 100);
        set_l0(0, 0, 4);
        set_l1(0, 0, 1);
        v = '0;
        v[0 +: 4] = 4'd15;
        run(v, "sat");
        check("sat_class", out_class, 0);
        check("sat_score", out_score, 160);
        check("sat_valid_s", out_valid_s, 1);
        check("sat_class_s", out_class_s, 0);
        check("sat_score_s", out_score_s, 127);
        release_out("sat");

        // Negative ReLU: hid1 = 0, class2 = 3 + hid1.
        clr_rom();
        set_l0(1, 11, -20);
        set_l1(2, 1, 1);
        set_l1(2, 4, 3);
        run(44'h0, "neg");
        check("neg_class", out_class, 2);
        check("neg_score", out_score, 3);
        check("neg_class_s", out_class_s, 2);
        check("neg_score_s", out_score_s, 3);
        release_out("neg");

        // Reset during L1 aborts without presenting a result.
        load_bias_only();
        inp      = 44'h0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
        end
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_busy_low", busy, 0);
        check("mid_class", out_class, 0);
        check("mid_score", out_score, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run(44'h0, "rerun");
        check("rerun_class", out_class, 2);
        check("rerun_score", out_score, 31);
        release_out("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_ax_mlp_classifier.md
Name: seq_ax_mlp_classifier

Overview:
- Time-multiplexed, parametrised two-layer MLP classifier for printed, resource-constrained circuits.
- Uses one shared MAC (multiply-accumulate) unit instead of one multiplier per weight.
- Approximation is a global product-LSB truncation. Hidden activations saturate to a narrow width.
- Pipeline: accept input vector → evaluate hidden layer (ReLU) → evaluate output layer (ReLU) → running argmax → class index out.
- Weights and biases come from an external ROM (read-only memory) over a same-cycle read port.

Parameters:
- NI, 11, number of inputs
- IW, 4, input width (unsigned)
- NH, 4, hidden neurons
- NO, 7, output neurons / classes
- WW, 8, weight/bias width (signed two's complement)
- AW, 16, accumulator width (signed)
- HW, 8, hidden activation width (unsigned, saturating)
- AX_TRUNC, 0, low bits zeroed in each product magnitude (0 = exact)
- ADW, 7, weight address width
- CW, 3, class index width; must be ≥ clog2(NO)

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- in_valid, in, 1, input vector valid
- in_ready, out, 1, block can accept a vector
- inp, in, NI*IW, input vector; input i is bits [i*IW+IW-1 : i*IW]
- w_addr, out, ADW, weight ROM address
- w_data, in, WW, signed weight/bias at w_addr, same cycle (combinational ROM)
- out_valid, out, 1, result valid
- out_ready, in, 1, consumer accepts result
- out_class, out, CW, argmax index
- out_score, out, AW-1, winning output score (post-ReLU)
- busy, out, 1, high in L0 and L1

Behaviour:
Reset:
- rst_n low forces state IDLE asynchronously.
- Reset values: in_ready=1, out_valid=0, out_class=0, out_score=0, busy=0, w_addr=0.
- Hidden registers and accumulator clear to 0.
- Reset mid-inference aborts it; no partial result is ever presented.

FSM states: IDLE, L0, L1, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch inp, set h=0, k=0, go to L0.
- L0, per hidden neuron h, NI+2 cycles:
  - k=0: acc ← sext(bias).
  - k=1..NI: acc ← acc ± trunc(|w|·x[k-1]); add if w ≥ 0, subtract if w < 0.
  - k=NI+1 (writeback): hid[h] ← 0 if acc<0, else min(acc, 2^HW−1).
  - After h=NH−1 writeback, go to L1 with o=0, k=0.
- L1, per output neuron o, NH+2 cycles: same sequence over hid[0..NH−1].
  - Writeback score s = 0 if acc<0, else acc[AW-2:0].
  - Running argmax: o=0 loads best; o>0 replaces best only if s > best (strict). Ties keep the lower index.
  - After o=NO−1, go to DONE.
- DONE: out_valid=1; out_class/out_score hold stable. On out_ready, go to IDLE (in_ready=1 next cycle).

Arithmetic:
- trunc(p) = p with bits [AX_TRUNC-1:0] forced 0.
- Products are formed on magnitudes, unsigned |w|(WW−1 bits) × x.
- The accumulator wraps on overflow. AW is sized by the integrator; overflow is outside the verified range.

Address map (w_addr is combinational from state/h/o/k):
- L0: h*(NI+1)+j for weight j; bias at j=NI.
- L1: NH*(NI+1) + o*(NH+1)+j for weight j; bias at j=NH.
- The bias is read at k=0; weight j=k−1 is read at k≥1.
- Defaults use 83 entries.

Latency:
- out_valid rises at the NH*(NI+2)+NO*(NH+2)-th rising edge after the accept edge.
- With defaults this is 94 cycles, independent of data.

Other rules:
- in_ready=0 in L0/L1/DONE; in_valid there is ignored.
- inp is sampled only on the accept edge; later changes to inp have no effect.
- out_ready in non-DONE states is ignored.
- Back-to-back inferences: the minimum gap is one IDLE cycle between out_ready acceptance and the next accept.

Test Plan:
- Bias-only: all weights 0, L1 biases [3,21,31,29,18,14,−24] → out_valid exactly 94 edges after accept, out_class=2, out_score=31.
- Tie-break: L1 biases [5,9,9,0,0,0,0], weights 0 → out_class=1, out_score=9.
- Truncation: AX_TRUNC=2, single L0 weight 1 on input 0 with x=7, L0 bias 0, hid[0] routed by L1 weight 1 to class 3 → out_score=4 (exact build: 7).
- Saturation plus negative ReLU:
  - HW=7, L0 neuron with bias 100 and weight 4·x, x=15 → hid=127 (not 160).
  - Neuron with bias −20 → hid=0.
  - Result checked through a L1 weight-1 path.
- Backpressure/handshake: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-L1: deassert rst_n at cycle 60 → out_valid=0, in_ready=1 immediately. Re-run the bias-only vector → correct result at 94 cycles.
